// File: rtl/onewire_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// onewire_ctrl - 1-wire master sequencer: bus reset/presence and read/write slots
// Rev 1.0
// -----------------------------------------------------------------------------
module onewire_ctrl #(
    parameter int CLK_DIV = 50,
    parameter int T_RSTL  = 480,
    parameter int T_RSTH  = 480,
    parameter int T_RSTP  = 70,
    parameter int T_DAT1  = 6,
    parameter int T_DATS  = 15,
    parameter int T_DAT0  = 60,
    parameter int T_REC   = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_dat,
    output logic       rsp_vld,
    output logic [7:0] rsp_dat,
    output logic       rsp_pres,
    output logic       busy,
    output logic       owr_pull,
    input  logic       owr_in
);

    localparam int c_max_t = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
    localparam int c_tw    = $clog2(c_max_t * CLK_DIV);

    localparam logic [c_tw-1:0] c_rstl_end = c_tw'(T_RSTL * CLK_DIV - 1);
    localparam logic [c_tw-1:0] c_rsth_end = c_tw'(T_RSTH * CLK_DIV - 1);
    localparam logic [c_tw-1:0] c_rstp_pt  = c_tw'(T_RSTP * CLK_DIV);
    localparam logic [c_tw-1:0] c_low_end  = c_tw'(T_DAT1 * CLK_DIV - 1);
    localparam logic [c_tw-1:0] c_data_end = c_tw'((T_DAT0 - T_DAT1) * CLK_DIV - 1);
    // Read sample point is counted from slot start, so offset by the low phase
    localparam logic [c_tw-1:0] c_samp_pt  = c_tw'((T_DATS - T_DAT1) * CLK_DIV);
    localparam logic [c_tw-1:0] c_rec_end  = c_tw'(T_REC * CLK_DIV - 1);

    localparam logic [1:0] c_op_rst  = 2'b00;
    localparam logic [1:0] c_op_bit  = 2'b01;
    localparam logic [1:0] c_op_byte = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_HIGH,
        S_SLOT_LOW,
        S_SLOT_DATA,
        S_SLOT_REC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic [1:0]      op_q, op_d;
    logic [7:0]      dat_q, dat_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            pres_q, pres_d;
    logic [7:0]      rsp_dat_q, rsp_dat_d;
    logic            rsp_pres_q, rsp_pres_d;
    logic            owr_pull_q, owr_pull_d;
    logic            sync1_q, owr_sync_q;

    // Idle bus floats high, so the synchronizer resets to 1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= 1'b1;
            owr_sync_q <= 1'b1;
        end else begin
            sync1_q    <= owr_in;
            owr_sync_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            op_q       <= 2'b00;
            dat_q      <= 8'h00;
            bit_q      <= 3'd0;
            shreg_q    <= 8'h00;
            pres_q     <= 1'b0;
            rsp_dat_q  <= 8'h00;
            rsp_pres_q <= 1'b0;
            owr_pull_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            op_q       <= op_d;
            dat_q      <= dat_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            pres_q     <= pres_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_pres_q <= rsp_pres_d;
            owr_pull_q <= owr_pull_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dat_d      = dat_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        pres_d     = pres_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_pres_d = rsp_pres_q;
        owr_pull_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_vld) begin
                    op_d    = cmd_op;
                    dat_d   = cmd_dat;
                    bit_d   = 3'd0;
                    shreg_d = 8'h00;
                    pres_d  = 1'b0;
                    case (cmd_op)
                        c_op_rst:            state_d = S_RST_LOW;
                        c_op_bit, c_op_byte: state_d = S_SLOT_LOW;
                        default: begin
                            state_d   = S_DONE;
                            rsp_dat_d = 8'h00;
                        end
                    endcase
                end
            end
            S_RST_LOW: begin
                if (timer_q == c_rstl_end) state_d = S_RST_HIGH;
            end
            S_RST_HIGH: begin
                if (timer_q == c_rstp_pt) pres_d = ~owr_sync_q;
                if (timer_q == c_rsth_end) begin
                    state_d    = S_DONE;
                    rsp_dat_d  = 8'h00;
                    rsp_pres_d = pres_q;
                end
            end
            S_SLOT_LOW: begin
                if (timer_q == c_low_end) state_d = S_SLOT_DATA;
            end
            S_SLOT_DATA: begin
                if (timer_q == c_samp_pt) shreg_d[bit_q] = owr_sync_q;
                if (timer_q == c_data_end) state_d = S_SLOT_REC;
            end
            S_SLOT_REC: begin
                if (timer_q == c_rec_end) begin
                    if (op_q == c_op_byte && bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_SLOT_LOW;
                    end else begin
                        state_d   = S_DONE;
                        rsp_dat_d = (op_q == c_op_byte) ? shreg_q : {7'd0, shreg_q[0]};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Timer restarts on every state entry and never runs while idle
        if (state_d != state_q || state_q == S_IDLE) timer_d = '0;
        else                                          timer_d = timer_q + 1'b1;

        // Pull is registered off the next state so the pad never sees decode glitches
        case (state_d)
            S_RST_LOW:   owr_pull_d = 1'b1;
            S_SLOT_LOW:  owr_pull_d = 1'b1;
            S_SLOT_DATA: owr_pull_d = ~dat_d[bit_d];
            default:     owr_pull_d = 1'b0;
        endcase
    end

    assign cmd_rdy  = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign rsp_vld  = (state_q == S_DONE);
    assign rsp_dat  = rsp_dat_q;
    assign rsp_pres = rsp_pres_q;
    assign owr_pull = owr_pull_q;

endmodule
`default_nettype wire

// File: tb/tb_onewire_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_onewire_ctrl - directed bench for onewire_ctrl with pull-up bus and slave model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_onewire_ctrl;

    logic       clk;
    logic       rstn;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic [1:0] cmd_op;
    logic [7:0] cmd_dat;
    logic       rsp_vld;
    logic [7:0] rsp_dat;
    logic       rsp_pres;
    logic       busy;
    logic       owr_pull;
    logic       owr_in;

    onewire_ctrl #(
        .CLK_DIV (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_op   (cmd_op),
        .cmd_dat  (cmd_dat),
        .rsp_vld  (rsp_vld),
        .rsp_dat  (rsp_dat),
        .rsp_pres (rsp_pres),
        .busy     (busy),
        .owr_pull (owr_pull),
        .owr_in   (owr_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: 0 = absent, 1 = presence pulse, 2 = read pattern
    int         mode = 0;
    logic [7:0] pat = 8'h00;
    int         slot_base = 0;

    logic prev_pull = 1'b0;
    int   low_cnt = 0;
    int   rel = 0;
    logic rel_active = 1'b0;
    int   slot_cnt = 0;
    int   since = 1000;
    int   widths[$];
    logic slave_low;
    int   sidx;

    always @(posedge clk) begin
        prev_pull <= owr_pull;
        if (owr_pull) begin
            low_cnt <= low_cnt + 1;
        end else begin
            low_cnt <= 0;
            if (low_cnt != 0) widths.push_back(low_cnt);
        end
        if (!owr_pull && prev_pull && low_cnt >= 900) begin
            rel_active <= 1'b1;
            rel        <= 0;
        end else if (rel_active) begin
            rel <= rel + 1;
        end
        if (owr_pull && !prev_pull) begin
            slot_cnt <= slot_cnt + 1;
            since    <= 0;
        end else begin
            since <= since + 1;
        end
    end

    always_comb begin
        slave_low = 1'b0;
        sidx      = slot_cnt - slot_base - 1;
        if (mode == 1 && rel_active && rel >= 120 && rel < 480) slave_low = 1'b1;
        if (mode == 2 && sidx >= 0 && sidx <= 7 && since < 60 && !pat[sidx[2:0]]) slave_low = 1'b1;
    end

    assign owr_in = ~(owr_pull | slave_low);

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int get_w(input int i);
        if (i < widths.size()) return widths[i];
        return -1;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] dat);
        @(negedge clk);
        cmd_op  = op;
        cmd_dat = dat;
        cmd_vld = 1'b1;
        @(posedge clk);
        #1 cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic got, output logic b1);
        lat = 0;
        got = 1'b0;
        b1  = 1'b0;
        while (!got && lat < 4000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) b1 = busy & ~cmd_rdy;
            if (rsp_vld) got = 1'b1;
        end
    endtask

    int          lat;
    logic        got;
    logic        b1;
    int          wb;
    logic        seen;
    int          exp_w[8] = '{12, 120, 12, 120, 120, 12, 120, 12};

    initial begin
        rstn    = 1'b0;
        cmd_vld = 1'b0;
        cmd_op  = 2'b00;
        cmd_dat = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rdy",  cmd_rdy,  1);
        check("rst_busy", busy,     0);
        check("rst_vld",  rsp_vld,  0);
        check("rst_dat",  rsp_dat,  0);
        check("rst_pres", rsp_pres, 0);
        check("rst_pull", owr_pull, 0);
        rstn = 1'b1;

        // Bus reset with a slave answering presence
        mode = 1;
        wb = widths.size();
        send_cmd(2'b00, 8'h00);
        wait_rsp(lat, got, b1);
        check("pres_got",   got, 1);
        check("pres_busy",  b1, 1);
        check("pres_lat",   lat, 1921);
        check("pres_flag",  rsp_pres, 1);
        check("pres_npul",  widths.size() - wb, 1);
        check("pres_width", get_w(wb), 960);

        // Byte write A5, bus echoes written bits
        mode = 0;
        wb = widths.size();
        send_cmd(2'b10, 8'hA5);
        wait_rsp(lat, got, b1);
        check("a5_got",  got, 1);
        check("a5_lat",  lat, 1041);
        check("a5_dat",  rsp_dat, 8'hA5);
        check("a5_pres_hold", rsp_pres, 1);
        check("a5_npul", widths.size() - wb, 8);
        for (int i = 0; i < 8; i++) check($sformatf("a5_w%0d", i), get_w(wb + i), exp_w[i]);

        // Reserved op: immediate response, no bus activity
        wb = widths.size();
        send_cmd(2'b11, 8'hAB);
        wait_rsp(lat, got, b1);
        check("res_got",  got, 1);
        check("res_lat",  lat, 1);
        check("res_dat",  rsp_dat, 0);
        check("res_pres", rsp_pres, 1);
        @(negedge clk);
        check("res_npul", widths.size() - wb, 0);
        check("res_pull", owr_pull, 0);

        // Bus reset with no slave
        send_cmd(2'b00, 8'h00);
        wait_rsp(lat, got, b1);
        check("nopres_lat",  lat, 1921);
        check("nopres_flag", rsp_pres, 0);

        // Byte read FF, slave returns 3C
        mode = 2;
        pat = 8'h3C;
        slot_base = slot_cnt;
        send_cmd(2'b10, 8'hFF);
        wait_rsp(lat, got, b1);
        check("rd3c_got", got, 1);
        check("rd3c_dat", rsp_dat, 8'h3C);

        // Single-bit read, slave holds low
        pat = 8'hFE;
        slot_base = slot_cnt;
        send_cmd(2'b01, 8'hFF);
        wait_rsp(lat, got, b1);
        check("bitrd_lat", lat, 131);
        check("bitrd_dat", rsp_dat, 8'h00);

        // Single-bit read 1, upper bits of cmd_dat must not leak
        mode = 0;
        send_cmd(2'b01, 8'h01);
        wait_rsp(lat, got, b1);
        check("bit1_dat", rsp_dat, 8'h01);

        // Single-bit write 0
        wb = widths.size();
        send_cmd(2'b01, 8'hFE);
        wait_rsp(lat, got, b1);
        check("bit0_lat",   lat, 131);
        check("bit0_dat",   rsp_dat, 8'h00);
        check("bit0_width", get_w(wb), 120);

        // Command while busy is ignored
        wb = widths.size();
        send_cmd(2'b01, 8'h01);
        repeat (5) begin
            @(negedge clk);
            cmd_op  = 2'b00;
            cmd_vld = 1'b1;
        end
        check("busy_rdy", cmd_rdy, 0);
        @(posedge clk);
        #1 cmd_vld = 1'b0;
        wait_rsp(lat, got, b1);
        check("busy_got", got, 1);
        repeat (5) @(negedge clk);
        check("busy_npul",  widths.size() - wb, 1);
        check("busy_width", get_w(wb), 12);
        check("busy_idle",  busy, 0);

        // Asynchronous reset in the middle of the reset low phase
        send_cmd(2'b00, 8'h00);
        repeat (480) @(negedge clk);
        check("mid_pull", owr_pull, 1);
        #2 rstn = 1'b0;
        #1 check("async_rel", owr_pull, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_vld) seen = 1'b1;
        end
        check("ar_no_rsp", seen, 0);
        check("ar_rdy",    cmd_rdy, 1);
        check("ar_pull",   owr_pull, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
